// File: rtl/state_count_pkg.sv
// state_count_pkg
// Shared definitions for the state_count word sequencer: default parameter
// values, the one-hot state encoding and a small sizing helper.
// No ports (package).
package state_count_pkg;

  localparam int DEPTH_DEF        = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int WRITE_CYCLES_DEF = 4;
  localparam int FORM_CYCLES_DEF  = 16;

  // One-hot state encoding; bit positions double as state indices.
  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_READ_BIT  = 1;
  localparam int ST_WRITE_BIT = 2;
  localparam int ST_FORM_BIT  = 3;
  localparam int ST_DONE_BIT  = 4;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001 << ST_IDLE_BIT,
    ST_READ  = 5'b00001 << ST_READ_BIT,
    ST_WRITE = 5'b00001 << ST_WRITE_BIT,
    ST_FORM  = 5'b00001 << ST_FORM_BIT,
    ST_DONE  = 5'b00001 << ST_DONE_BIT
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/state_count_if.sv
// state_count_if
// Control-side bundle of the state_count sequencer.
//   en_state_count     : count enable from control
//   re/we/forming_writeread : mode selects from control
//   count_add          : current word address (ADDR_W bits)
//   cache/write/forming_count_flag : operation-complete flags
//   mode_err           : only with STATE_COUNT_MODE_CHECK_EN, flags a
//                        multi-mode request seen in IDLE
// Modports: master = control block, slave = state_count.
interface state_count_if
  import state_count_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              en_state_count;
  logic              re_writeread;
  logic              we_writeread;
  logic              forming_writeread;
  logic [ADDR_W-1:0] count_add;
  logic              cache_count_flag;
  logic              write_count_flag;
  logic              forming_count_flag;
`ifdef STATE_COUNT_MODE_CHECK_EN
  logic              mode_err;
`endif

  modport master (
    output en_state_count,
    output re_writeread,
    output we_writeread,
    output forming_writeread,
    input  count_add,
    input  cache_count_flag,
    input  write_count_flag,
`ifdef STATE_COUNT_MODE_CHECK_EN
    input  mode_err,
`endif
    input  forming_count_flag
  );

  modport slave (
    input  en_state_count,
    input  re_writeread,
    input  we_writeread,
    input  forming_writeread,
    output count_add,
    output cache_count_flag,
    output write_count_flag,
`ifdef STATE_COUNT_MODE_CHECK_EN
    output mode_err,
`endif
    output forming_count_flag
  );

endinterface

// File: rtl/state_count_timer.sv
// count_timer
// Loadable up-counter with a terminal-count compare.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : synchronous load of load_val (wins over inc)
//   load_val  : value loaded on load
//   inc       : count up by one
//   tc_val    : terminal-count value
//   tc        : combinational, high while count == tc_val
module count_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/state_count.sv
// state_count
// Word sequencer for read / write / forming operations. Steps count_add
// through DEPTH words (read: one per clock, write: one per WRITE_CYCLES
// clocks), or times a single FORM_CYCLES forming pulse, then raises the
// matching completion flag and holds it until en_state_count drops.
// Ports:
//   clk : clock, all state on rising edge
//   CE  : asynchronous active-high reset
//   bus : state_count_if.slave (enable, mode selects, count_add, flags)
// Optional feature: define STATE_COUNT_MODE_CHECK_EN to add bus.mode_err,
// a one-clock pulse after an IDLE clock with enable and >1 mode select.
//
// state | meaning
// IDLE  | waiting for enable + mode; count_add and timer held at 0
// READ  | count_add +1 per clock up to DEPTH-1
// WRITE | timer runs WRITE_CYCLES per word, count_add +1 per timer wrap
// FORM  | count_add held 0, timer runs FORM_CYCLES
// DONE  | completion flag and final count_add held until enable drops
module state_count
  import state_count_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int WRITE_CYCLES = WRITE_CYCLES_DEF,
  parameter int FORM_CYCLES  = FORM_CYCLES_DEF
) (
  input logic         clk,
  input logic         CE,
  state_count_if.slave bus
);

  localparam int TIMER_W = $clog2(max_int(WRITE_CYCLES, FORM_CYCLES) + 1);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TIMER_W-1:0] WR_LAST   = TIMER_W'(WRITE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FM_LAST   = TIMER_W'(FORM_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              cache_q, cache_d;
  logic              write_q, write_d;
  logic              form_q,  form_d;

  logic               timer_load;
  logic               timer_inc;
  logic [TIMER_W-1:0] timer_tc_val;
  logic               timer_tc;

  logic en;
  logic multi_mode;

  assign en         = bus.en_state_count;
  assign multi_mode = (bus.re_writeread & bus.we_writeread) |
                      (bus.re_writeread & bus.forming_writeread) |
                      (bus.we_writeread & bus.forming_writeread);

  count_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (CE),
    .load     (timer_load),
    .load_val ('0),
    .inc      (timer_inc),
    .tc_val   (timer_tc_val),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk or posedge CE) begin
    if (CE) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      cache_q <= 1'b0;
      write_q <= 1'b0;
      form_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cache_q <= cache_d;
      write_q <= write_d;
      form_q  <= form_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cache_d      = cache_q;
    write_d      = write_q;
    form_d       = form_q;
    timer_load   = 1'b0;
    timer_inc    = 1'b0;
    timer_tc_val = WR_LAST;

    unique case (state_q)
      ST_IDLE: begin
        count_d    = '0;
        cache_d    = 1'b0;
        write_d    = 1'b0;
        form_d     = 1'b0;
        timer_load = 1'b1;
        // Priority forming > write > read when several selects are high.
        if (en) begin
          if (bus.forming_writeread)  state_d = ST_FORM;
          else if (bus.we_writeread)  state_d = ST_WRITE;
          else if (bus.re_writeread)  state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (!en) begin
          state_d    = ST_IDLE;
          count_d    = '0;
          timer_load = 1'b1;
        end else if (count_q == LAST_ADDR) begin
          state_d = ST_DONE;
          cache_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_WRITE: begin
        timer_tc_val = WR_LAST;
        if (!en) begin
          state_d    = ST_IDLE;
          count_d    = '0;
          timer_load = 1'b1;
        end else if (timer_tc) begin
          // Timer wrap ends one word; the last word ends the operation
          // instead of advancing, so count_add stops at DEPTH-1.
          timer_load = 1'b1;
          if (count_q == LAST_ADDR) begin
            state_d = ST_DONE;
            write_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end

      ST_FORM: begin
        timer_tc_val = FM_LAST;
        count_d      = '0;
        if (!en) begin
          state_d    = ST_IDLE;
          timer_load = 1'b1;
        end else if (timer_tc) begin
          state_d    = ST_DONE;
          form_d     = 1'b1;
          timer_load = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end

      ST_DONE: begin
        timer_load = 1'b1;
        if (!en) begin
          state_d = ST_IDLE;
          count_d = '0;
          cache_d = 1'b0;
          write_d = 1'b0;
          form_d  = 1'b0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        count_d    = '0;
        cache_d    = 1'b0;
        write_d    = 1'b0;
        form_d     = 1'b0;
        timer_load = 1'b1;
      end
    endcase
  end

  assign bus.count_add          = count_q;
  assign bus.cache_count_flag   = cache_q;
  assign bus.write_count_flag   = write_q;
  assign bus.forming_count_flag = form_q;

`ifdef STATE_COUNT_MODE_CHECK_EN
  logic mode_err_q;

  always_ff @(posedge clk or posedge CE) begin
    if (CE) begin
      mode_err_q <= 1'b0;
    end else begin
      mode_err_q <= (state_q == ST_IDLE) && en && multi_mode;
    end
  end

  assign bus.mode_err = mode_err_q;
`else
  // Without the check the selects resolve by priority alone.
  logic unused_multi_mode;
  assign unused_multi_mode = multi_mode;
`endif

endmodule

// File: doc/state_count.md
STATE_COUNT -- requirements
Module: state_count

Interface
REQ-001 Parameter DEPTH, default 32, number of cache/register words per read or write operation.
REQ-002 Parameter ADDR_W, default 5, width of count_add; 2**ADDR_W SHALL be >= DEPTH.
REQ-003 Parameter WRITE_CYCLES, default 4, clocks of write pulse per word.
REQ-004 Parameter FORM_CYCLES, default 16, total clocks of one forming operation.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 CE  input  1  asynchronous active-high reset.
REQ-007 en_state_count  input  1  count enable from control.
REQ-008 re_writeread / we_writeread / forming_writeread  input  1 each  mode selects from control.
REQ-009 count_add  output  ADDR_W  current word address to writeread and data register.
REQ-010 cache_count_flag / write_count_flag / forming_count_flag  output  1 each  operation-complete flags to control.

Function
REQ-011 States: IDLE, READ, WRITE, FORM, DONE; one-hot encoded; all outputs registered.
REQ-012 IDLE: en_state_count=1 with mode select -> mode state next edge; count_add=0, timer=0; priority forming > write > read.
REQ-013 IDLE with en_state_count=0 or no mode select -> stay IDLE.
REQ-014 READ: count_add +1 per clock; at count_add==DEPTH-1 -> DONE, cache_count_flag=1 on same edge; flag first high DEPTH clocks after the entry edge.
REQ-015 WRITE: timer counts 0..WRITE_CYCLES-1 per word; at timer wrap count_add +1; at count_add==DEPTH-1 and timer==WRITE_CYCLES-1 -> DONE, write_count_flag=1; flag high DEPTH*WRITE_CYCLES clocks after entry.
REQ-016 FORM: count_add held 0; timer counts to FORM_CYCLES-1 -> DONE, forming_count_flag=1; flag high FORM_CYCLES clocks after entry.
REQ-017 DONE: completed mode's flag and final count_add held while en_state_count=1; en_state_count=0 -> IDLE, all flags 0, count_add=0.
REQ-018 Any mode state with en_state_count=0 -> abort to IDLE next edge, no flag raised.
REQ-019 Mode select changes inside a mode state are ignored; mode is latched at entry.
REQ-020 count_add never exceeds DEPTH-1; no wrap to 0 within an operation.
REQ-021 At most one completion flag high at any time.

Reset
REQ-022 CE=1 forces, asynchronously: state IDLE, count_add=0, timer=0, all flags 0.
REQ-023 CE asserted mid-operation SHALL discard progress; after release the block starts from IDLE.
REQ-024 Reset release takes effect on the first rising clk edge with CE=0.

Configuration
REQ-025 Macro STATE_COUNT_MODE_CHECK_EN: when defined, output mode_err (1 bit) is added, set for one clock after any clock in IDLE where en_state_count=1 and more than one mode select is high, cleared by CE.
REQ-026 Without STATE_COUNT_MODE_CHECK_EN: no mode_err port; priority of REQ-012 applies silently.

Structure
REQ-027 Shared package state_count_pkg holds state one-hot constants, DEPTH/ADDR_W/WRITE_CYCLES/FORM_CYCLES defaults.
REQ-028 One sub-module count_timer (loadable up-counter with terminal-count output) instantiated for the per-word/forming timer; the address counter stays in state_count.

Verification
REQ-029 Read: CE=0, en_state_count=1, re_writeread=1 -> count_add 0..31 on successive clocks, cache_count_flag=1 at clock 32, held until en_state_count=0 then 0 next clock.
REQ-030 Write: we_writeread=1 with enable -> count_add steps every 4 clocks, write_count_flag=1 at clock 128, count_add=31 held in DONE.
REQ-031 Forming: forming_writeread=1 with enable -> count_add stays 0, forming_count_flag=1 at clock 16.
REQ-032 Abort: start read, drop en_state_count at clock 10 -> IDLE next edge, count_add=0, no flag ever asserted.
REQ-033 Reset mid-write: CE pulse at clock 50 -> outputs 0 immediately without clock; fresh write after release completes at clock 128.
REQ-034 Conflict (macro defined): re_writeread=1 and forming_writeread=1 with enable -> FORM entered, mode_err=1 for one clock, forming_count_flag=1 at clock 16.
